// File: rtl/updown_sweep_ctrl_if.sv
// Bundle between the sweep sequencer and its surroundings: the requester's
// command/status signals plus the control and feedback lines of the loadable
// up/down counter.
//
//   start, stop           request / abort from the requester
//   mode, lo, hi          sweep shape and bounds (captured on accepted start)
//   num_pass              ping-pong leg count (captured on accepted start)
//   cnt_q                 counter output fed back to the sequencer
//   cnt_din/en/load/in    counter direction, step enable, load, load value
//   busy, done, aborted   sweep status back to the requester
//   err                   one-cycle pulse for a rejected start
//
// master: requester + counter side.  slave: the sequencer.
interface updown_sweep_ctrl_if #(
  parameter int unsigned N  = 10,
  parameter int unsigned PW = 8
);
  logic          start;
  logic          stop;
  logic [1:0]    mode;
  logic [N-1:0]  lo;
  logic [N-1:0]  hi;
  logic [PW-1:0] num_pass;
  logic [N-1:0]  cnt_q;
  logic          cnt_din;
  logic          cnt_en;
  logic          cnt_load;
  logic [N-1:0]  cnt_in;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          err;

  modport master (
    output start, stop, mode, lo, hi, num_pass, cnt_q,
    input  cnt_din, cnt_en, cnt_load, cnt_in, busy, done, aborted, err
  );

  modport slave (
    input  start, stop, mode, lo, hi, num_pass, cnt_q,
    output cnt_din, cnt_en, cnt_load, cnt_in, busy, done, aborted, err
  );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Sequencer for a loadable N-bit up/down counter. Runs a programmed sweep
// between two bounds (up, down, or ping-pong for a number of legs), owns the
// counter's initialisation through Load, and reports busy/done/err.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   updown_sweep_ctrl_if.slave: command inputs, counter feedback,
//         counter controls and status outputs
//
// State walk: IDLE -> LOAD (one cycle) -> RUN (until target / stop) ->
// DONE (one cycle) -> IDLE.
module updown_sweep_ctrl #(
  parameter int unsigned N  = 10,
  parameter int unsigned PW = 8
) (
  input logic                clk,
  input logic                rst,
  updown_sweep_ctrl_if.slave bus
);

  localparam logic [1:0] ModeDown = 2'b01;
  localparam logic [1:0] ModePing = 2'b10;
  localparam logic [1:0] ModeRsvd = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [PW-1:0] passes_left_q, passes_left_d;
  logic          dir_q, dir_d;
  logic          aborted_q, aborted_d;
  logic          err_q, err_d;

  logic          start_bad;
  logic [N-1:0]  target;
  logic          at_target;

  logic          cnt_din;
  logic          cnt_en;
  logic          cnt_load;
  logic [N-1:0]  cnt_in;
  logic          busy;
  logic          done;
  logic          aborted;

  assign start_bad = (bus.mode == ModeRsvd) || (bus.lo > bus.hi);

  // The leg currently running heads for hi when counting up, lo when down.
  assign target    = dir_q ? hi_q : lo_q;
  assign at_target = (bus.cnt_q == target);

  // Next-state and outputs.
  always_comb begin
    state_d       = state_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    passes_left_d = passes_left_q;
    dir_d         = dir_q;
    aborted_d     = aborted_q;
    err_d         = 1'b0;

    cnt_din  = 1'b0;
    cnt_en   = 1'b0;
    cnt_load = 1'b0;
    cnt_in   = '0;
    busy     = 1'b0;
    done     = 1'b0;
    aborted  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (start_bad) begin
            err_d = 1'b1;
          end else begin
            lo_d      = bus.lo;
            hi_d      = bus.hi;
            dir_d     = (bus.mode != ModeDown);
            aborted_d = 1'b0;
            if (bus.mode == ModePing) begin
              passes_left_d = (bus.num_pass == '0) ? PW'(1) : bus.num_pass;
            end else begin
              passes_left_d = PW'(1);
            end
            state_d = StLoad;
          end
        end
      end

      StLoad: begin
        busy     = 1'b1;
        cnt_load = 1'b1;
        // Start from the bound opposite the first target.
        cnt_in   = dir_q ? lo_q : hi_q;
        if (bus.stop) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else begin
          state_d = StRun;
        end
      end

      StRun: begin
        busy    = 1'b1;
        cnt_din = dir_q;
        if (bus.stop) begin
          // Stop beats a target match and freezes the counter this cycle.
          aborted_d = 1'b1;
          state_d   = StDone;
        end else if (at_target) begin
          if (passes_left_q <= PW'(1)) begin
            aborted_d = 1'b0;
            state_d   = StDone;
          end else begin
            // Turnaround: one dwell cycle with the counter held.
            dir_d         = ~dir_q;
            passes_left_d = passes_left_q - PW'(1);
          end
        end else begin
          // Enable depends on live cnt_q so the counter halts exactly on target.
          cnt_en = 1'b1;
        end
      end

      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        aborted = aborted_q;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      lo_q          <= '0;
      hi_q          <= '0;
      passes_left_q <= '0;
      dir_q         <= 1'b0;
      aborted_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
      passes_left_q <= passes_left_d;
      dir_q         <= dir_d;
      aborted_q     <= aborted_d;
      err_q         <= err_d;
    end
  end

  assign bus.cnt_din  = cnt_din;
  assign bus.cnt_en   = cnt_en;
  assign bus.cnt_load = cnt_load;
  assign bus.cnt_in   = cnt_in;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.aborted  = aborted;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: a behavioural counter, a timeline model that
// lays out each sweep cycle-by-cycle from the bounds and leg count, and one
// compare process that checks the DUT against the timeline every cycle.
module tb_updown_sweep_ctrl;
  localparam int unsigned N  = 10;
  localparam int unsigned PW = 8;
  localparam logic [N-1:0] One = 1;

  typedef struct {
    logic         st;      // stimulus: start
    logic         sp;      // stimulus: stop
    logic         rs;      // stimulus: rst
    logic         busy;
    logic         load;
    logic         en;
    logic         din;
    logic         done;
    logic         aborted;
    logic         err;
    logic [N-1:0] in;
    logic [N-1:0] q;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] ctr_q = 10'h2a5;

  rec_t tl[$];
  rec_t cur;
  bit   chk = 1'b0;
  int   total = 0;
  int   bad = 0;

  updown_sweep_ctrl_if #(.N(N), .PW(PW)) bus ();

  updown_sweep_ctrl #(.N(N), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // The controlled counter: no reset, load wins over enable.
  always @(posedge clk) begin
    if (bus.cnt_load)    ctr_q <= bus.cnt_in;
    else if (bus.cnt_en) ctr_q <= bus.cnt_din ? ctr_q + One : ctr_q - One;
  end
  assign bus.cnt_q = ctr_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (chk) begin
      check("busy", 32'(bus.busy), 32'(cur.busy));
      check("done", 32'(bus.done), 32'(cur.done));
      check("err", 32'(bus.err), 32'(cur.err));
      check("cnt_load", 32'(bus.cnt_load), 32'(cur.load));
      check("cnt_en", 32'(bus.cnt_en), 32'(cur.en));
      check("cnt_q", 32'(bus.cnt_q), 32'(cur.q));
      if (cur.en)   check("cnt_din", 32'(bus.cnt_din), 32'(cur.din));
      if (cur.load) check("cnt_in", 32'(bus.cnt_in), 32'(cur.in));
      if (cur.done) check("aborted", 32'(bus.aborted), 32'(cur.aborted));
    end
  end

  function automatic rec_t idle_rec();
    rec_t r;
    r.st = 0; r.sp = 0; r.rs = 0; r.busy = 0; r.load = 0; r.en = 0; r.din = 0;
    r.done = 0; r.aborted = 0; r.err = 0; r.in = '0; r.q = '0;
    return r;
  endfunction

  // Counter value per cycle follows from the expected load/step pattern.
  task automatic fill_q();
    logic [N-1:0] q;
    rec_t r;
    q = ctr_q;
    for (int t = 0; t < tl.size(); t++) begin
      r = tl[t];
      r.q = q;
      tl[t] = r;
      if (r.load)    q = r.in;
      else if (r.en) q = r.din ? q + One : q - One;
    end
  endtask

  task automatic truncate(input int keep);
    while (tl.size() > keep) void'(tl.pop_back());
  endtask

  // Lay out one sweep. Cycle 0 presents start; stop_at / rst_at (>0) inject
  // an abort or a reset in that cycle.
  task automatic build(input int mode, input int lo, input int hi, input int np,
                       input int stop_at, input int rst_at, input bit start_in_done);
    rec_t r;
    int   legs, span, done_idx;
    tl.delete();
    r = idle_rec(); r.st = 1; tl.push_back(r);
    if (mode == 3 || lo > hi) begin
      r = idle_rec(); r.err = 1; tl.push_back(r);
      tl.push_back(idle_rec());
    end else begin
      r = idle_rec(); r.busy = 1; r.load = 1; r.in = N'(mode == 1 ? hi : lo);
      tl.push_back(r);
      legs = (mode == 2) ? ((np == 0) ? 1 : np) : 1;
      span = hi - lo;
      for (int l = 0; l < legs; l++) begin
        for (int s = 0; s <= span; s++) begin
          r = idle_rec(); r.busy = 1;
          r.din = (mode != 1) ^ l[0];
          r.en = (s < span);
          tl.push_back(r);
        end
      end
      r = idle_rec(); r.busy = 1; r.done = 1; tl.push_back(r);
      tl.push_back(idle_rec());
      done_idx = tl.size() - 2;
      if (stop_at > 0 && stop_at < done_idx) begin
        r = tl[stop_at]; r.en = 0; r.sp = 1; tl[stop_at] = r;
        truncate(stop_at + 1);
        r = idle_rec(); r.busy = 1; r.done = 1; r.aborted = 1; tl.push_back(r);
        tl.push_back(idle_rec());
        done_idx = stop_at + 1;
      end
      // Start and stop are ignored while busy / in DONE; exercise that.
      for (int t = 1; t < tl.size(); t++) begin
        r = tl[t];
        if (r.busy) r.st = 1'($urandom_range(0, 1));
        if (r.done) r.sp = 1'($urandom_range(0, 1));
        if (r.done && start_in_done) r.st = 1;
        tl[t] = r;
      end
      if (rst_at > 0 && rst_at <= done_idx) begin
        r = tl[rst_at]; r.rs = 1; r.sp = 0; tl[rst_at] = r;
        truncate(rst_at + 1);
        for (int k = 0; k < 4; k++) tl.push_back(idle_rec());
      end
    end
    fill_q();
  endtask

  task automatic run(input int mode, input int lo, input int hi, input int np);
    for (int t = 0; t < tl.size(); t++) begin
      @(negedge clk);
      rst       = tl[t].rs;
      bus.start = tl[t].st;
      bus.stop  = tl[t].sp;
      if (t == 0) begin
        bus.mode = 2'(mode); bus.lo = N'(lo); bus.hi = N'(hi); bus.num_pass = PW'(np);
      end else begin
        bus.mode = 2'($urandom_range(0, 3));
        bus.lo = N'($urandom); bus.hi = N'($urandom); bus.num_pass = PW'($urandom);
      end
      cur = tl[t];
      chk = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic sweep(input int mode, input int lo, input int hi, input int np,
                       input int stop_at, input int rst_at, input bit start_in_done);
    build(mode, lo, hi, np, stop_at, rst_at, start_in_done);
    run(mode, lo, hi, np);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pp_seq[9];
    int mode, lo, hi, np, stop_at, rst_at, sel, lim;
    pp_seq = '{2, 3, 4, 4, 3, 2, 2, 3, 4};
    bus.start = 0; bus.stop = 0; bus.mode = 0; bus.lo = '0; bus.hi = '0; bus.num_pass = '0;
    repeat (2) @(negedge clk);

    // Reset state: two cycles in reset, then idle.
    tl.delete();
    begin
      rec_t r;
      r = idle_rec(); r.rs = 1; tl.push_back(r); tl.push_back(r);
      tl.push_back(idle_rec()); tl.push_back(idle_rec());
    end
    fill_q();
    run(0, 0, 0, 0);

    // Up 3..7 with start held during DONE.
    build(0, 3, 7, 0, 0, 0, 1'b1);
    check("m_up_len", tl.size(), 9);
    check("m_up_in", 32'(tl[1].in), 3);
    check("m_up_q6", 32'(tl[6].q), 7);
    check("m_up_en6", 32'(tl[6].en), 0);
    check("m_up_done7", 32'(tl[7].done), 1);
    run(0, 3, 7, 0);

    // Down full range, no wrap.
    build(1, 0, 1023, 0, 0, 0, 1'b0);
    check("m_dn_q2", 32'(tl[2].q), 1023);
    check("m_dn_q1025", 32'(tl[1025].q), 0);
    check("m_dn_done", 32'(tl[1026].done), 1);
    run(1, 0, 1023, 0);

    // Ping-pong 2..4, three legs.
    build(2, 2, 4, 3, 0, 0, 1'b0);
    for (int i = 0; i < 9; i++) check("m_pp_q", 32'(tl[2 + i].q), 32'(pp_seq[i]));
    check("m_pp_done", 32'(tl[11].done), 1);
    run(2, 2, 4, 3);

    // Stop at cnt_q=5 in an up sweep 0..9.
    build(0, 0, 9, 0, 7, 0, 1'b0);
    check("m_stop_q", 32'(tl[7].q), 5);
    check("m_stop_ab", 32'(tl[8].aborted), 1);
    check("m_stop_hold", 32'(tl[9].q), 5);
    run(0, 0, 9, 0);

    // Rejected starts.
    build(0, 8, 4, 0, 0, 0, 1'b0);
    check("m_rej_err", 32'(tl[1].err), 1);
    run(0, 8, 4, 0);
    sweep(3, 1, 5, 0, 0, 0, 1'b0);

    // Reset mid-run: last step lands on 6 and the counter stays there.
    build(0, 0, 9, 0, 0, 7, 1'b0);
    check("m_rst_q", 32'(tl[8].q), 6);
    check("m_rst_busy", 32'(tl[8].busy), 0);
    check("m_rst_hold", 32'(tl[11].q), 6);
    run(0, 0, 9, 0);

    // lo == hi ping-pong: only dwell cycles.
    sweep(2, 500, 500, 4, 0, 0, 1'b0);

    // Random sweeps.
    for (int k = 0; k < 80; k++) begin
      mode = $urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2);
      lo = $urandom_range(0, 1023);
      hi = lo + $urandom_range(0, 12);
      if (hi > 1023) hi = 1023;
      if ($urandom_range(0, 9) == 0 && lo != hi) begin
        np = lo; lo = hi; hi = np;
      end
      np = $urandom_range(0, 4);
      lim = (mode == 2) ? ((np == 0) ? 1 : np) * (hi - lo + 1) + 1 : (hi - lo + 2);
      sel = $urandom_range(0, 7);
      stop_at = (sel < 2) ? $urandom_range(1, lim) : 0;
      rst_at  = (sel == 2) ? $urandom_range(1, lim) : 0;
      sweep(mode, lo, hi, np, stop_at, rst_at, 1'($urandom_range(0, 1)));
    end

    chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
